// File: rtl/custom_axi_accel_if.sv
// Request/response bus of the multi-channel accelerator.
// The slave modport is the accelerator's view; the master modport is the requester's view.
interface custom_axi_accel_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [CH_W-1:0]       in_ch_i;
  logic [1:0]            in_op_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [CH_W-1:0]       out_ch_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_ovf_o;
  logic                  out_err_o;

  modport slave (
    input  in_valid_i, in_ch_i, in_op_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_ch_o, out_data_o, out_ovf_o, out_err_o
  );

  modport master (
    output in_valid_i, in_ch_i, in_op_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_ch_o, out_data_o, out_ovf_o, out_err_o
  );
endinterface

// File: rtl/custom_axi_accel.sv
// Multi-channel increment / add-operand / accumulate engine with a
// valid/ready request port and a held valid/ready response port.
module custom_axi_accel #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  custom_axi_accel_if.slave     bus,
  input  logic                  cfg_we_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  acc_clr_i,
  output logic [1:0]            status_o,
  output logic [15:0]           done_cnt_o
);
  localparam int CH_W = $clog2(NUM_CH);

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic [15:0]           done_cnt_q, done_cnt_d;
  logic [DATA_WIDTH-1:0] acc_q [NUM_CH];
  logic [DATA_WIDTH-1:0] acc_d [NUM_CH];

  logic                  ch_ok_s;
  logic                  illegal_s;
  logic                  consume_s;
  logic [DATA_WIDTH-1:0] acc_sel_s;
  logic [DATA_WIDTH:0]   sum_s;

  // Request legality and accumulator select; channel range is checked by enumeration.
  always_comb begin
    ch_ok_s   = 1'b0;
    acc_sel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ok_s   = (bus.in_ch_i == CH_W'(i)) ? 1'b1 : ch_ok_s;
      acc_sel_s = (ch_q == CH_W'(i)) ? acc_q[i] : acc_sel_s;
    end
    illegal_s = (bus.in_op_i == 2'b11) || !ch_ok_s;
    consume_s = ((state_q == ST_DONE) || (state_q == ST_ERROR)) && bus.out_ready_i;
  end

  always_comb begin
    case (op_q)
      OP_INC:  sum_s = {1'b0, data_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
      OP_ADD:  sum_s = {1'b0, data_q} + {1'b0, opnd_q};
      OP_ACC:  sum_s = {1'b0, acc_sel_s} + {1'b0, data_q};
      default: sum_s = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          state_d = illegal_s ? ST_ERROR : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: state_d = ST_DONE;
      ST_DONE, ST_ERROR: begin
        if (bus.out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  // Datapath next values; a coincident clear wins over the accumulate write-back.
  always_comb begin
    ch_d       = ch_q;
    op_d       = op_q;
    data_d     = data_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    opnd_d     = cfg_we_i ? cfg_data_i : opnd_q;
    done_cnt_d = consume_s ? done_cnt_q + 16'd1 : done_cnt_q;
    if ((state_q == ST_IDLE) && bus.in_valid_i) begin
      ch_d   = bus.in_ch_i;
      op_d   = bus.in_op_i;
      data_d = bus.in_data_i;
    end else if (state_q == ST_BUSY) begin
      {ovf_d, res_d} = sum_s;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i] = ((op_q == OP_ACC) && (ch_q == CH_W'(i))) ? sum_s[DATA_WIDTH-1:0] : acc_q[i];
      end
    end else begin
      res_d = res_q;
    end
    if (acc_clr_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i] = '0;
      end
    end else begin
      ovf_d = ovf_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_q       <= '0;
      op_q       <= 2'b00;
      data_q     <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      opnd_q     <= '0;
      done_cnt_q <= 16'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      ch_q       <= ch_d;
      op_q       <= op_d;
      data_q     <= data_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      opnd_q     <= opnd_d;
      done_cnt_q <= done_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  // Outputs decoded from registered state and result.
  always_comb begin
    bus.in_ready_o  = (state_q == ST_IDLE);
    bus.out_valid_o = (state_q == ST_DONE) || (state_q == ST_ERROR);
    bus.out_err_o   = (state_q == ST_ERROR);
    bus.out_ch_o    = bus.out_valid_o ? ch_q : '0;
    bus.out_data_o  = (state_q == ST_DONE) ? res_q : '0;
    bus.out_ovf_o   = (state_q == ST_DONE) ? ovf_q : 1'b0;
    status_o        = state_q;
    done_cnt_o      = done_cnt_q;
  end
endmodule

// File: tb/tb_custom_axi_accel.sv
// Directed scoreboard bench for custom_axi_accel: expected responses are
// queued from a reference model when requests are issued and checked on output.
module tb_custom_axi_accel;
  localparam int DW = 32;
  localparam int NC = 4;

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] data;
    logic          ovf;
    logic          err;
  } resp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_we_i = 1'b0;
  logic [DW-1:0] cfg_data_i = '0;
  logic          acc_clr_i = 1'b0;
  logic [1:0]    status_o;
  logic [15:0]   done_cnt_o;

  int total = 0;
  int bad   = 0;

  resp_t         sb[$];
  resp_t         last_exp;
  logic [DW-1:0] m_acc [NC];
  logic [DW-1:0] m_opnd;
  logic [15:0]   m_cnt;

  custom_axi_accel_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

  custom_axi_accel #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus),
    .cfg_we_i   (cfg_we_i),
    .cfg_data_i (cfg_data_i),
    .acc_clr_i  (acc_clr_i),
    .status_o   (status_o),
    .done_cnt_o (done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_acc[i] = '0;
    m_opnd = '0;
    m_cnt  = 16'd0;
    sb.delete();
  endtask

  // Compute expected result, push it, then perform the handshake in IDLE.
  task automatic send(input logic [1:0] ch, input logic [1:0] op, input logic [DW-1:0] d);
    resp_t        e;
    logic [DW:0]  s;
    e.ch = ch;
    e.err = (op == 2'b11);
    case (op)
      2'b00:   s = {1'b0, d} + 33'd1;
      2'b01:   s = {1'b0, d} + {1'b0, m_opnd};
      2'b10:   s = {1'b0, m_acc[ch]} + {1'b0, d};
      default: s = 33'd0;
    endcase
    e.data = s[DW-1:0];
    e.ovf  = s[DW];
    if (op == 2'b10) m_acc[ch] = s[DW-1:0];
    sb.push_back(e);
    bus.in_valid_i = 1'b1;
    bus.in_ch_i    = ch;
    bus.in_op_i    = op;
    bus.in_data_i  = d;
    chk("req_ready", {63'd0, bus.in_ready_o}, 64'd1);
    @(posedge clk_i);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  // Wait lat negedges; the last must show the queued response.
  task automatic check_resp(input int lat);
    resp_t e;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk_i);
      chk("early_valid", {63'd0, bus.out_valid_o}, 64'd0);
      chk("busy_status", {62'd0, status_o}, 64'd1);
    end
    @(negedge clk_i);
    chk("out_valid", {63'd0, bus.out_valid_o}, 64'd1);
    chk("busy_not_ready", {63'd0, bus.in_ready_o}, 64'd0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=response expected=none_pending");
    end else begin
      e = sb.pop_front();
      last_exp = e;
      chk("out_ch", {62'd0, bus.out_ch_o}, {62'd0, e.ch});
      chk("out_data", {32'd0, bus.out_data_o}, {32'd0, e.data});
      chk("out_ovf", {63'd0, bus.out_ovf_o}, {63'd0, e.ovf});
      chk("out_err", {63'd0, bus.out_err_o}, {63'd0, e.err});
      chk("resp_status", {62'd0, status_o}, e.err ? 64'd3 : 64'd2);
    end
  endtask

  task automatic consume();
    bus.out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.out_ready_i = 1'b0;
    m_cnt = m_cnt + 16'd1;
    @(negedge clk_i);
    chk("idle_ready", {63'd0, bus.in_ready_o}, 64'd1);
    chk("idle_status", {62'd0, status_o}, 64'd0);
    chk("idle_valid", {63'd0, bus.out_valid_o}, 64'd0);
    chk("done_cnt", {48'd0, done_cnt_o}, {48'd0, m_cnt});
  endtask

  task automatic cfg_write(input logic [DW-1:0] v);
    cfg_we_i   = 1'b1;
    cfg_data_i = v;
    @(posedge clk_i);
    #1;
    cfg_we_i = 1'b0;
    m_opnd   = v;
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_ch_i     = '0;
    bus.in_op_i     = 2'b00;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    model_reset();

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", {63'd0, bus.in_ready_o}, 64'd1);
    chk("rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    chk("rst_status", {62'd0, status_o}, 64'd0);
    chk("rst_cnt", {48'd0, done_cnt_o}, 64'd0);
    chk("rst_data", {32'd0, bus.out_data_o}, 64'd0);
    chk("rst_ch_ovf_err", {61'd0, bus.out_ch_o, bus.out_ovf_o, bus.out_err_o}, 64'd0);

    // INC basics and wrap with carry.
    send(2'd2, 2'b00, 32'h0000_0005);
    check_resp(2);
    consume();
    send(2'd0, 2'b00, 32'hFFFF_FFFF);
    check_resp(2);
    consume();

    // ADD with operand register; mid-BUSY write must not affect the result.
    cfg_write(32'h10);
    send(2'd1, 2'b01, 32'h20);
    check_resp(2);
    consume();
    send(2'd1, 2'b01, 32'h1);
    cfg_we_i   = 1'b1;
    cfg_data_i = 32'h100;
    @(posedge clk_i);
    #1;
    cfg_we_i = 1'b0;
    m_opnd   = 32'h100;
    check_resp(1);
    consume();
    send(2'd2, 2'b01, 32'h1);
    check_resp(2);
    consume();

    // Accumulate on ch1; other channels stay zero.
    for (int i = 1; i <= 4; i++) begin
      send(2'd1, 2'b10, 32'(i));
      check_resp(2);
      consume();
    end
    send(2'd0, 2'b10, 32'h0);
    check_resp(2);
    consume();
    send(2'd3, 2'b10, 32'h0);
    check_resp(2);
    consume();

    // Illegal op: one-cycle error response, accumulators untouched.
    send(2'd0, 2'b11, 32'hDEAD_BEEF);
    check_resp(1);
    consume();
    send(2'd1, 2'b10, 32'h0);
    check_resp(2);
    consume();

    // Clear during BUSY of an ACC: reported sum survives, storage is cleared.
    send(2'd1, 2'b10, 32'h5);
    acc_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    acc_clr_i = 1'b0;
    for (int i = 0; i < NC; i++) m_acc[i] = '0;
    check_resp(1);
    consume();
    send(2'd1, 2'b10, 32'h1);
    check_resp(2);
    consume();

    // Backpressure hold, then reset while in DONE.
    send(2'd3, 2'b00, 32'h7);
    check_resp(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("hold_valid", {63'd0, bus.out_valid_o}, 64'd1);
      chk("hold_data", {32'd0, bus.out_data_o}, {32'd0, last_exp.data});
      chk("hold_ch", {62'd0, bus.out_ch_o}, {62'd0, last_exp.ch});
      chk("hold_ready", {63'd0, bus.in_ready_o}, 64'd0);
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    chk("mid_rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    chk("mid_rst_status", {62'd0, status_o}, 64'd0);
    chk("mid_rst_cnt", {48'd0, done_cnt_o}, 64'd0);

    // Operand register was cleared by reset.
    send(2'd1, 2'b01, 32'h3);
    check_resp(2);
    consume();

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
